// File: rtl/pio128_pkg.sv
// -----------------------------------------------------------------------------
// pio128_pkg
// Shared definitions for the blocks that feed the 128-bit HPS result FIFO.
//   PIO_DATA_W - beat width of the FIFO / Avalon read PIO.
//   ERR_CNT_W  - width of the saturating error-release counter.
//   arb_state_e - two-state arbiter FSM encoding.
//   sat_inc    - saturating increment for the error counter.
// -----------------------------------------------------------------------------
package pio128_pkg;

    localparam int PIO_DATA_W = 128;
    localparam int ERR_CNT_W  = 16;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } arb_state_e;

    // Counts up but sticks at all-ones so a long-running system never wraps
    // back to a clean-looking zero.
    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (v == '1) ? v : v + ERR_CNT_W'(1);
    endfunction

endpackage

// File: rtl/pio128_fifo_write_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational rotating-priority encoder. Scans the valid vector starting at
// the index just after last_grant and wrapping modulo NUM_REQ; the first set
// bit wins, so the previous winner has the lowest priority.
// Ports:
//   valid      in  NUM_REQ          request vector
//   last_grant in  $clog2(NUM_REQ)  index of the previous winner
//   winner     out $clog2(NUM_REQ)  selected index (0 when nothing is valid)
//   any_valid  out 1                at least one request present
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         valid,
    input  logic [$clog2(NUM_REQ)-1:0] last_grant,
    output logic [$clog2(NUM_REQ)-1:0] winner,
    output logic                       any_valid
);

    localparam int IW = $clog2(NUM_REQ);
    // One spare bit so last_grant + k (k <= NUM_REQ) never overflows before
    // the modulo fold.
    localparam int SW = IW + 1;

    logic [SW-1:0] sum;
    logic [IW-1:0] idx;
    logic          found;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        sum    = '0;
        idx    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            sum = {1'b0, last_grant} + SW'(k);
            if (sum >= SW'(NUM_REQ)) begin
                sum = sum - SW'(NUM_REQ);
            end
            idx = sum[IW-1:0];
            if (!found && valid[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    assign any_valid = |valid;

endmodule

// File: rtl/pio128_fifo_write_arbiter.sv
// -----------------------------------------------------------------------------
// pio128_fifo_write_arbiter
// Round-robin, packet-locked arbiter sharing the single 128-bit HPS result FIFO
// between NUM_REQ producer streams. A grant is held until the holder's last
// beat so multi-word results stay contiguous in the FIFO; a stalled holder is
// evicted after IDLE_TIMEOUT idle cycles and a runaway one after MAX_BURST
// beats, each flagged with a one-cycle error pulse and counted.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   req_valid/last/data   per-requester beat interface (data flattened,
//                         requester i at [i*DATA_W +: DATA_W])
//   req_ready             per-requester accept, only the holder can see it
//   fifo_full             shared FIFO back-pressure
//   fifo_wr, fifo_din     FIFO write port (combinational from the holder)
//   grant_valid, grant_id current holder (id held while idle)
//   err_timeout/err_burst one-cycle pulses on forced releases
//   err_count             saturating count of forced releases
// -----------------------------------------------------------------------------
module pio128_fifo_write_arbiter
    import pio128_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int DATA_W       = PIO_DATA_W,
    parameter int MAX_BURST    = 16,
    parameter int IDLE_TIMEOUT = 255
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ-1:0]          req_last,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic                        fifo_full,
    output logic                        fifo_wr,
    output logic [DATA_W-1:0]           fifo_din,
    output logic                        grant_valid,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        err_timeout,
    output logic                        err_burst,
    output logic [ERR_CNT_W-1:0]        err_count
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int TW = $clog2(IDLE_TIMEOUT + 1);

    arb_state_e           state_q, state_d;
    logic                 grant_valid_q, grant_valid_d;
    logic [IW-1:0]        grant_id_q, grant_id_d;
    logic [IW-1:0]        last_grant_q, last_grant_d;
    logic [BW-1:0]        beat_cnt_q, beat_cnt_d;
    logic [TW-1:0]        idle_cnt_q, idle_cnt_d;
    logic                 err_timeout_q, err_timeout_d;
    logic                 err_burst_q, err_burst_d;
    logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

    logic [IW-1:0]        rr_winner;
    logic                 rr_any;

    logic                 stream_active;
    logic                 holder_valid;
    logic                 holder_last;
    logic [DATA_W-1:0]    holder_data;
    logic                 accept;
    logic                 release_grant;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .valid      (req_valid),
        .last_grant (last_grant_q),
        .winner     (rr_winner),
        .any_valid  (rr_any)
    );

    // Holder-side datapath. Reset gates the handshake in the same cycle so a
    // grant is dropped immediately rather than after the reset edge.
    always_comb begin
        stream_active = (state_q == STREAM) && !reset;
        holder_valid  = req_valid[grant_id_q];
        holder_last   = req_last[grant_id_q];
        holder_data   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id_q == IW'(i)) begin
                holder_data = req_data[i*DATA_W +: DATA_W];
            end
        end

        accept    = stream_active && holder_valid && !fifo_full;
        req_ready = '0;
        if (stream_active && !fifo_full) begin
            req_ready[grant_id_q] = 1'b1;
        end
        fifo_wr  = accept;
        // Drive zeros rather than a stale/unknown slice when not writing.
        fifo_din = accept ? holder_data : '0;
    end

    always_comb begin
        state_d       = state_q;
        grant_valid_d = grant_valid_q;
        grant_id_d    = grant_id_q;
        last_grant_d  = last_grant_q;
        beat_cnt_d    = beat_cnt_q;
        idle_cnt_d    = idle_cnt_q;
        err_timeout_d = 1'b0;
        err_burst_d   = 1'b0;
        err_count_d   = err_count_q;
        release_grant = 1'b0;

        case (state_q)
            IDLE: begin
                // Arbitration takes this whole cycle; no beat is accepted.
                if (rr_any) begin
                    state_d       = STREAM;
                    grant_valid_d = 1'b1;
                    grant_id_d    = rr_winner;
                    beat_cnt_d    = '0;
                    idle_cnt_d    = '0;
                end
            end
            STREAM: begin
                if (accept) begin
                    beat_cnt_d = beat_cnt_q + BW'(1);
                    idle_cnt_d = '0;
                    // Last beat wins over the burst cap: a packet of exactly
                    // MAX_BURST beats is a clean release.
                    if (holder_last) begin
                        release_grant = 1'b1;
                    end else if (beat_cnt_d == BW'(MAX_BURST)) begin
                        release_grant = 1'b1;
                        err_burst_d   = 1'b1;
                    end
                end else if (!holder_valid) begin
                    // Valid-but-full is back-pressure, not idleness, so only
                    // a missing beat advances the timeout.
                    idle_cnt_d = idle_cnt_q + TW'(1);
                    if (idle_cnt_d == TW'(IDLE_TIMEOUT)) begin
                        release_grant = 1'b1;
                        err_timeout_d = 1'b1;
                    end
                end

                if (release_grant) begin
                    state_d       = IDLE;
                    grant_valid_d = 1'b0;
                    last_grant_d  = grant_id_q;
                end
                if (err_timeout_d || err_burst_d) begin
                    err_count_d = sat_inc(err_count_q);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            grant_valid_q <= 1'b0;
            grant_id_q    <= '0;
            last_grant_q  <= IW'(NUM_REQ - 1);
            beat_cnt_q    <= '0;
            idle_cnt_q    <= '0;
            err_timeout_q <= 1'b0;
            err_burst_q   <= 1'b0;
            err_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            grant_valid_q <= grant_valid_d;
            grant_id_q    <= grant_id_d;
            last_grant_q  <= last_grant_d;
            beat_cnt_q    <= beat_cnt_d;
            idle_cnt_q    <= idle_cnt_d;
            err_timeout_q <= err_timeout_d;
            err_burst_q   <= err_burst_d;
            err_count_q   <= err_count_d;
        end
    end

    assign grant_valid = grant_valid_q;
    assign grant_id    = grant_id_q;
    assign err_timeout = err_timeout_q;
    assign err_burst   = err_burst_q;
    assign err_count   = err_count_q;

endmodule

// File: tb/tb_pio128_fifo_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_pio128_fifo_write_arbiter
// Producers are per-requester beat queues honouring valid/ready. A reference
// model built from the arbitration rules (round-robin scan, packet lock, burst
// cap, idle timeout, saturating error count) predicts every output each cycle.
// Inputs are driven 1 time unit after the rising edge, outputs sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_pio128_fifo_write_arbiter;

    localparam int N    = 4;
    localparam int DW   = 128;
    localparam int MAXB = 16;
    localparam int TMO  = 255;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     req_valid, req_last, req_ready;
    logic [DW-1:0]    dat [N];
    logic [N*DW-1:0]  req_data;
    logic             fifo_full, fifo_wr;
    logic [DW-1:0]    fifo_din;
    logic             grant_valid, err_timeout, err_burst;
    logic [1:0]       grant_id;
    logic [15:0]      err_count;

    always #5 clk = ~clk;

    assign req_data = {dat[3], dat[2], dat[1], dat[0]};

    pio128_fifo_write_arbiter #(
        .NUM_REQ (N), .DATA_W (DW), .MAX_BURST (MAXB), .IDLE_TIMEOUT (TMO)
    ) dut (
        .clk (clk), .reset (reset),
        .req_valid (req_valid), .req_last (req_last), .req_data (req_data),
        .req_ready (req_ready), .fifo_full (fifo_full),
        .fifo_wr (fifo_wr), .fifo_din (fifo_din),
        .grant_valid (grant_valid), .grant_id (grant_id),
        .err_timeout (err_timeout), .err_burst (err_burst), .err_count (err_count)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    beat_t         bq [N][$];
    bit            holding [N];
    bit            full_pat [$];
    int            gap_pct, full_pct;
    bit            rst_req;

    // reference model state
    bit            m_gv, m_eb, m_et;
    logic [1:0]    m_gid, m_last;
    int            m_beats, m_idle;
    int            m_errs;

    logic [DW-1:0] wlog [$];
    int            cyc_n, wcyc, tcyc, nb_pulse, nt_pulse;
    int            nchk, npass;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        nchk++;
        if (got === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc_n);
    endtask

    function automatic logic [1:0] rr_model(input logic [N-1:0] v, input logic [1:0] last);
        for (int k = 1; k <= N; k++) begin
            int idx = (int'(last) + k) % N;
            if (v[idx[1:0]]) return idx[1:0];
        end
        return 2'd0;
    endfunction

    function automatic logic [DW-1:0] wl(input int k);
        return (k < wlog.size()) ? wlog[k] : '1;
    endfunction

    task automatic push(input int i, input logic [DW-1:0] d, input bit last);
        beat_t b;
        b.data = d;
        b.last = last;
        bq[i].push_back(b);
    endtask

    task automatic drive();
        reset = rst_req;
        if (full_pat.size() > 0) fifo_full = full_pat.pop_front();
        else fifo_full = ($urandom_range(99) < full_pct);
        for (int i = 0; i < N; i++) begin
            if (!holding[i]) begin
                if (bq[i].size() > 0 && $urandom_range(99) >= gap_pct) begin
                    req_valid[i] = 1'b1;
                    dat[i]       = bq[i][0].data;
                    req_last[i]  = bq[i][0].last;
                end else begin
                    req_valid[i] = 1'b0;
                    req_last[i]  = 1'b0;
                end
            end
        end
    endtask

    task automatic model_release(input logic [1:0] g, input bit is_err);
        m_gv   = 1'b0;
        m_last = g;
        if (is_err && m_errs < 'hFFFF) m_errs++;
    endtask

    task automatic sample();
        logic [N-1:0] exp_rdy;
        logic         exp_wr;
        logic [1:0]   g;
        if (fifo_wr) begin wlog.push_back(fifo_din); wcyc = cyc_n; end
        if (err_burst) nb_pulse++;
        if (err_timeout) begin nt_pulse++; tcyc = cyc_n; end
        if (reset) begin
            chk("rst_req_ready", DW'(req_ready), DW'(0));
            chk("rst_fifo_wr", DW'(fifo_wr), DW'(0));
            m_gv = 0; m_gid = 0; m_last = 2'(N - 1); m_beats = 0; m_idle = 0;
            m_eb = 0; m_et = 0; m_errs = 0;
        end else begin
            chk("grant_valid", DW'(grant_valid), DW'(m_gv));
            chk("grant_id", DW'(grant_id), DW'(m_gid));
            chk("err_burst", DW'(err_burst), DW'(m_eb));
            chk("err_timeout", DW'(err_timeout), DW'(m_et));
            chk("err_count", DW'(err_count), DW'(m_errs));
            g       = m_gid;
            exp_rdy = '0;
            exp_wr  = 1'b0;
            if (m_gv) begin
                exp_rdy[g] = !fifo_full;
                exp_wr     = req_valid[g] && !fifo_full;
            end
            chk("req_ready", DW'(req_ready), DW'(exp_rdy));
            chk("fifo_wr", DW'(fifo_wr), DW'(exp_wr));
            if (exp_wr) begin
                chk("fifo_din", fifo_din, bq[g][0].data);
                if (fifo_din !== bq[g][0].data) ;
            end
            if (!exp_wr) chk("fifo_din_idle", fifo_din, '0);
            m_eb = 0;
            m_et = 0;
            if (!m_gv) begin
                if (req_valid != '0) begin
                    m_gv = 1; m_gid = rr_model(req_valid, m_last); m_beats = 0; m_idle = 0;
                end
            end else if (exp_wr) begin
                m_beats++;
                m_idle = 0;
                if (req_last[g]) model_release(g, 1'b0);
                else if (m_beats == MAXB) begin model_release(g, 1'b1); m_eb = 1; end
            end else if (!req_valid[g]) begin
                m_idle++;
                if (m_idle == TMO) begin model_release(g, 1'b1); m_et = 1; end
            end
        end
        for (int i = 0; i < N; i++) begin
            if (req_valid[i] && req_ready[i] && bq[i].size() > 0) void'(bq[i].pop_front());
            holding[i] = req_valid[i] && !req_ready[i];
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        drive();
        @(negedge clk);
        sample();
        cyc_n++;
    endtask

    function automatic bit queues_empty();
        for (int i = 0; i < N; i++) if (bq[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic run_idle(input int budget);
        int c = 0;
        while (!(queues_empty() && !m_gv) && c < budget) begin
            cyc();
            c++;
        end
        if (c >= budget) chk("drain_budget", DW'(0), DW'(1));
        cyc();
    endtask

    initial begin
        int nb0, nt0, c;
        nchk = 0; npass = 0; cyc_n = 0; nb_pulse = 0; nt_pulse = 0;
        reset = 1'b1; req_valid = '0; req_last = '0; fifo_full = 1'b0;
        for (int i = 0; i < N; i++) begin dat[i] = '0; holding[i] = 0; end
        gap_pct = 0; full_pct = 0;
        m_gv = 0; m_gid = 0; m_last = 2'(N - 1); m_errs = 0; m_eb = 0; m_et = 0;

        // reset, then check reset values on the first free cycle
        rst_req = 1;
        repeat (2) cyc();
        rst_req = 0;
        cyc();
        chk("reset_grant_valid", DW'(grant_valid), DW'(0));
        chk("reset_grant_id", DW'(grant_id), DW'(0));
        chk("reset_err_count", DW'(err_count), DW'(0));

        // 1: all four requesters, 2-beat packets -> 0,0,1,1,2,2,3,3
        wlog.delete();
        for (int i = 0; i < N; i++)
            for (int b = 0; b < 2; b++) push(i, DW'(i * 256 + b), b == 1);
        run_idle(200);
        chk("t1_writes", DW'(wlog.size()), DW'(8));
        for (int k = 0; k < 8; k++) chk("t1_order", wl(k), DW'((k / 2) * 256 + k % 2));
        chk("t1_err_count", DW'(err_count), DW'(0));

        // 2: requester 2 under toggling full, requester 1 waiting throughout
        wlog.delete();
        for (int b = 0; b < 3; b++) push(2, DW'('h200 + b), b == 2);
        cyc();
        push(1, DW'('h100), 1'b0);
        push(1, DW'('h101), 1'b1);
        for (int k = 0; k < 8; k++) full_pat.push_back(k % 2 == 0);
        run_idle(200);
        chk("t2_writes", DW'(wlog.size()), DW'(5));
        for (int k = 0; k < 3; k++) chk("t2_contig", wl(k), DW'('h200 + k));
        chk("t2_next_req1", wl(3), DW'('h100));

        // 3: 20 beats from requester 0 with no last -> burst cap, then 1 wins
        wlog.delete();
        nb0 = nb_pulse; nt0 = nt_pulse;
        for (int b = 0; b < 20; b++) push(0, DW'('h300 + b), 1'b0);
        push(1, DW'('h3F0), 1'b1);
        run_idle(1000);
        for (int k = 0; k < 16; k++) chk("t3_burst_data", wl(k), DW'('h300 + k));
        chk("t3_req1_next", wl(16), DW'('h3F0));
        chk("t3_burst_pulses", DW'(nb_pulse - nb0), DW'(1));
        chk("t3_tmo_pulses", DW'(nt_pulse - nt0), DW'(1));
        chk("t3_err_count", DW'(err_count), DW'(2));

        // 4: idle timeout; a 300-cycle full stall with valid held must not time out
        nt0 = nt_pulse;
        push(3, DW'('h400), 1'b0);
        push(3, DW'('h401), 1'b0);
        full_pat.push_back(0);
        full_pat.push_back(0);
        for (int k = 0; k < 300; k++) full_pat.push_back(1);
        run_idle(1200);
        chk("t4_tmo_pulses", DW'(nt_pulse - nt0), DW'(1));
        // pulse follows the IDLE_TIMEOUT-th idle cycle after the last write
        chk("t4_tmo_gap", DW'(tcyc - wcyc), DW'(TMO + 1));
        chk("t4_err_count", DW'(err_count), DW'(3));

        // 5: reset in the middle of requester 1's 4-beat packet
        for (int b = 0; b < 4; b++) push(1, DW'('h500 + b), b == 3);
        c = 0;
        while (!(m_gv && m_gid == 2'd1 && m_beats == 2) && c < 50) begin cyc(); c++; end
        chk("t5_reach_beat2", DW'(c < 50), DW'(1));
        rst_req = 1;
        cyc();
        rst_req = 0;
        push(0, DW'('h5F0), 1'b1);
        wlog.delete();
        cyc();
        chk("t5_post_gv", DW'(grant_valid), DW'(0));
        chk("t5_post_wr", DW'(fifo_wr), DW'(0));
        chk("t5_post_errs", DW'(err_count), DW'(0));
        cyc();
        chk("t5_first_winner", DW'(grant_id), DW'(0));
        run_idle(200);
        chk("t5_req0_first", wl(0), DW'('h5F0));
        chk("t5_req1_resume", wl(1), DW'('h502));

        // 6: error counter saturates at 16'hFFFF
        cyc();
        @(posedge clk);
        #2 force dut.err_count_q = 16'hFFFE;
        #1 release dut.err_count_q;
        m_errs = 'hFFFE;
        cyc();
        chk("t6_preload", DW'(err_count), DW'('hFFFE));
        nb0 = nb_pulse;
        for (int b = 0; b < 3 * MAXB; b++) push(2, DW'('h600 + b), 1'b0);
        run_idle(400);
        chk("t6_burst_pulses", DW'(nb_pulse - nb0), DW'(3));
        chk("t6_saturated", DW'(err_count), DW'('hFFFF));

        // random traffic from a clean reset
        rst_req = 1;
        cyc();
        rst_req = 0;
        gap_pct = 15;
        full_pct = 25;
        for (int i = 0; i < N; i++)
            for (int p = 0; p < 60; p++) begin
                int len = $urandom_range(20, 1);
                for (int b = 0; b < len; b++)
                    push(i, {$urandom, $urandom, $urandom, $urandom}, b == len - 1);
            end
        run_idle(30000);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
